plu_controller: RTL and testbench

- Control FSM that drives the write enables of the PLU datapath: weight, activation and the three pipeline registers (r1, r2, r3).
- Sequences one 4-input multiply / add-tree / ReLU pass per iteration.
- Supports Maxnet recurrence: iteration 0 loads external activations; later iterations load the fed-back PLU outputs through an activation-source select.
- Sits between the Maxnet top-level sequencer (start/done handshake) and the PLU datapath enables.

---
 rtl/plu_pkg.sv | 17 +
 rtl/plu_controller_if.sv | 39 +++
 rtl/plu_controller.sv | 112 +++++++++++
 tb/tb_plu_controller.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/plu_pkg.sv
// Shared types and constants for the PLU control path.
package plu_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StMul,
        StAdd,
        StRelu,
        StNext
    } plu_state_e;

    localparam int unsigned PLU_STAGES = 4;
    localparam logic        A_SEL_EXT  = 1'b0;
    localparam logic        A_SEL_FB   = 1'b1;

endpackage

// File: rtl/plu_controller_if.sv
// Sequencer handshake plus PLU datapath enables.
// PLU_CTRL_EARLY_STOP_EN adds the converged input.
interface plu_controller_if #(
    parameter int unsigned ITER_W = 8
);
`ifdef PLU_CTRL_EARLY_STOP_EN
    logic              converged;
`endif
    logic              start;
    logic [ITER_W-1:0] num_iter;
    logic              ready;
    logic              busy;
    logic              w_we;
    logic              a_we;
    logic              a_sel;
    logic              r1_we;
    logic              r2_we;
    logic              r3_we;
    logic              out_valid;
    logic [ITER_W-1:0] iter_idx;
    logic              done;

    modport master (
`ifdef PLU_CTRL_EARLY_STOP_EN
        output converged,
`endif
        output start, num_iter,
        input  ready, busy, w_we, a_we, a_sel, r1_we, r2_we, r3_we, out_valid, iter_idx, done
    );

    modport slave (
`ifdef PLU_CTRL_EARLY_STOP_EN
        input  converged,
`endif
        input  start, num_iter,
        output ready, busy, w_we, a_we, a_sel, r1_we, r2_we, r3_we, out_valid, iter_idx, done
    );

endinterface

// File: rtl/plu_controller.sv
// PLU control FSM: one LOAD/MUL/ADD/RELU/NEXT pass per Maxnet iteration.
// PLU_CTRL_EARLY_STOP_EN lets converged end the run in NEXT.
module plu_controller
    import plu_pkg::*;
#(
    parameter int unsigned ITER_W = 8
) (
    input logic             clk,
    input logic             rst,
    plu_controller_if.slave bus
);

    plu_state_e        state_q;
    logic [ITER_W-1:0] iter_q;
    logic [ITER_W-1:0] last_q;
    logic              ready_q, busy_q, w_we_q, a_we_q, a_sel_q;
    logic              r1_we_q, r2_we_q, r3_we_q, out_valid_q, done_q;
    logic              stop;

`ifdef PLU_CTRL_EARLY_STOP_EN
    assign stop     = (iter_q == last_q) || bus.converged;
    // converged is only seen in NEXT, so it must act within that same cycle
    assign bus.done = done_q | ((state_q == StNext) & bus.converged);
`else
    assign stop     = (iter_q == last_q);
    assign bus.done = done_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            iter_q      <= '0;
            last_q      <= '0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            w_we_q      <= 1'b0;
            a_we_q      <= 1'b0;
            a_sel_q     <= A_SEL_EXT;
            r1_we_q     <= 1'b0;
            r2_we_q     <= 1'b0;
            r3_we_q     <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // Outputs are computed for the state being entered
            w_we_q      <= 1'b0;
            a_we_q      <= 1'b0;
            r1_we_q     <= 1'b0;
            r2_we_q     <= 1'b0;
            r3_we_q     <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        last_q  <= (bus.num_iter == '0) ? '0 : bus.num_iter - ITER_W'(1);
                        iter_q  <= '0;
                        state_q <= StLoad;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        w_we_q  <= 1'b1;
                        a_we_q  <= 1'b1;
                        a_sel_q <= A_SEL_EXT;
                    end
                end
                StLoad: begin
                    state_q <= StMul;
                    r1_we_q <= 1'b1;
                end
                StMul: begin
                    state_q <= StAdd;
                    r2_we_q <= 1'b1;
                end
                StAdd: begin
                    state_q <= StRelu;
                    r3_we_q <= 1'b1;
                end
                StRelu: begin
                    state_q     <= StNext;
                    out_valid_q <= 1'b1;
                    done_q      <= (iter_q == last_q);
                end
                StNext: begin
                    if (stop) begin
                        state_q <= StIdle;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        a_sel_q <= A_SEL_EXT;
                    end else begin
                        iter_q  <= iter_q + ITER_W'(1);
                        state_q <= StLoad;
                        a_we_q  <= 1'b1;
                        a_sel_q <= A_SEL_FB;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.ready     = ready_q;
    assign bus.busy      = busy_q;
    assign bus.w_we      = w_we_q;
    assign bus.a_we      = a_we_q;
    assign bus.a_sel     = a_sel_q;
    assign bus.r1_we     = r1_we_q;
    assign bus.r2_we     = r2_we_q;
    assign bus.r3_we     = r3_we_q;
    assign bus.out_valid = out_valid_q;
    assign bus.iter_idx  = iter_q;

endmodule

// File: tb/tb_plu_controller.sv
// Directed bench for plu_controller; define PLU_CTRL_EARLY_STOP_EN to cover early stop.
module tb_plu_controller;
    import plu_pkg::*;

    localparam int unsigned ITER_W = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_bad;

    plu_controller_if #(.ITER_W(ITER_W)) bus ();

    plu_controller #(.ITER_W(ITER_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {w_we, a_we, a_sel, r1_we, r2_we, r3_we, out_valid, done, ready, busy}
    logic [9:0] obs;
    assign obs = {bus.w_we, bus.a_we, bus.a_sel, bus.r1_we, bus.r2_we, bus.r3_we,
                  bus.out_valid, bus.done, bus.ready, bus.busy};

    // Phase 0..4 = LOAD..NEXT of iteration i; anything else = IDLE
    function automatic logic [9:0] exp_vec(input int p, input int i, input logic last);
        logic s;
        s = (i != 0);
        case (p)
            0:       exp_vec = (i == 0) ? 10'b1100000001 : 10'b0110000001;
            1:       exp_vec = {2'b00, s, 3'b100, 4'b0001};
            2:       exp_vec = {2'b00, s, 3'b010, 4'b0001};
            3:       exp_vec = {2'b00, s, 3'b001, 4'b0001};
            4:       exp_vec = {2'b00, s, 3'b000, 1'b1, last, 2'b01};
            default: exp_vec = 10'b0000000010;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a run and check every cycle; poke re-asserts start with a new count during ADD
    task automatic run(input int nreq, input int neff, input bit poke);
        bus.num_iter = ITER_W'(nreq);
        bus.start    = 1'b1;
        step();
        bus.start    = 1'b0;
        for (int i = 0; i < neff; i++) begin
            for (int p = 0; p < PLU_STAGES + 1; p++) begin
                check($sformatf("run%0d i%0d p%0d outs", nreq, i, p), 32'(obs),
                      32'(exp_vec(p, i, i == neff - 1)));
                check($sformatf("run%0d i%0d p%0d idx", nreq, i, p), 32'(bus.iter_idx), 32'(i));
                if (poke && i == 0 && p == 2) begin
                    bus.start    = 1'b1;
                    bus.num_iter = ITER_W'(5);
                end
                step();
                bus.start = 1'b0;
            end
        end
        check($sformatf("run%0d idle", nreq), 32'(obs), 32'(exp_vec(5, 0, 1'b0)));
    endtask

    initial begin
        n_checks     = 0;
        n_bad        = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.num_iter = '0;
`ifdef PLU_CTRL_EARLY_STOP_EN
        bus.converged = 1'b0;
`endif
        #12;
        check("reset outs", 32'(obs), 32'(10'b0000000010));
        check("reset idx", 32'(bus.iter_idx), 32'd0);
        rst = 1'b0;
        step();

        run(1, 1, 1'b0);
        run(3, 3, 1'b0);
        run(0, 1, 1'b0);
        run(2, 2, 1'b1);
        step();
        check("no queued start", 32'(obs), 32'(exp_vec(5, 0, 1'b0)));

        // Async reset in RELU of iteration 1
        bus.num_iter = ITER_W'(3);
        bus.start    = 1'b1;
        step();
        bus.start    = 1'b0;
        repeat (8) step();
        check("pre-rst relu", 32'(obs), 32'(exp_vec(3, 1, 1'b0)));
        #2 rst = 1'b1;
        #1;
        check("mid rst outs", 32'(obs), 32'(exp_vec(5, 0, 1'b0)));
        check("mid rst idx", 32'(bus.iter_idx), 32'd0);
        #3 rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("post rst idle c%0d", c), 32'(obs), 32'(exp_vec(5, 0, 1'b0)));
        end
        run(2, 2, 1'b0);

        // Start held high: one IDLE cycle between runs
        bus.num_iter = ITER_W'(1);
        bus.start    = 1'b1;
        step();
        for (int p = 0; p < 5; p++) begin
            check($sformatf("hold p%0d", p), 32'(obs), 32'(exp_vec(p, 0, 1'b1)));
            step();
        end
        check("hold idle gap", 32'(obs), 32'(exp_vec(5, 0, 1'b0)));
        step();
        check("hold restart", 32'(obs), 32'(exp_vec(0, 0, 1'b1)));
        bus.start = 1'b0;
        repeat (5) step();
        check("hold end idle", 32'(obs), 32'(exp_vec(5, 0, 1'b0)));

`ifdef PLU_CTRL_EARLY_STOP_EN
        bus.num_iter = ITER_W'(10);
        bus.start    = 1'b1;
        step();
        bus.start    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 5; p++) begin
                if (i == 1 && p == 4) begin
                    bus.converged = 1'b1;
                    #1;
                end
                check($sformatf("es i%0d p%0d", i, p), 32'(obs), 32'(exp_vec(p, i, i == 1)));
                step();
            end
        end
        bus.converged = 1'b0;
        check("es idle", 32'(obs), 32'(exp_vec(5, 0, 1'b0)));
        check("es idx", 32'(bus.iter_idx), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
